// File: rtl/shift_seq_pkg.sv
// Shared definitions for the serial shift sequencer.
//   state_t   : FSM state encoding (IDLE/LOAD/SHIFT/DONE).
//   cnt_width : width of a counter spanning 0..n-1, never less than 1 bit.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned MIN_CNT_W = 1;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? MIN_CNT_W : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Handshake and serial-output bundle for shift_seq_ctrl.
//   master : producer/consumer side (drives in_valid, in_data, abort)
//   slave  : controller side (drives in_ready, ser_out, ser_valid, busy, done)
interface shift_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             abort;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, ser_out, ser_valid, busy, done
  );

endinterface

// File: rtl/shift_seq_ctrl_chain.sv
// shift_chain: parallel-load, shift-left register feeding the serial output.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din (has priority over shift)
//   shift    : shift left by one, zero fill
//   din      : parallel word
//   msb      : current most significant bit
module shift_chain #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q << 1;
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts a parallel word over valid/ready and shifts it out
// MSB-first, each bit held DIV clocks, followed by a one-cycle done pulse.
//   clk, rst  : clock, synchronous active-high reset
//   bus.slave : in_valid/in_data/in_ready handshake, abort,
//               ser_out/ser_valid serial output, busy, done
// Build option: SHIFT_SEQ_PARITY_EN appends an even-parity bit after the LSB.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 2
) (
  input logic             clk,
  input logic             rst,
  shift_seq_ctrl_if.slave bus
);

`ifdef SHIFT_SEQ_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif

  localparam int unsigned DIV_W = cnt_width(DIV);
  localparam int unsigned BIT_W = cnt_width(NBITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               ser_out_q;
  logic               ser_valid_q;
  logic               done_q;

  logic               accept;
  logic               chain_shift;
  logic               chain_msb;
  logic [NBITS-1:0]   chain_din;

  assign bus.in_ready = (state == IDLE) & ~rst;
  assign accept       = bus.in_valid & bus.in_ready;

  // Word (and parity) are captured straight into the chain on accept, so
  // later in_data changes cannot disturb the transfer.
`ifdef SHIFT_SEQ_PARITY_EN
  assign chain_din = {bus.in_data, ^bus.in_data};
`else
  assign chain_din = bus.in_data;
`endif

  assign chain_shift = (state == SHIFT) & ~bus.abort & (div_cnt == DIV_LAST);

  shift_chain #(
    .W(NBITS)
  ) u_chain (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(chain_shift),
    .din  (chain_din),
    .msb  (chain_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          done_q      <= 1'b0;
          if (accept) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= bus.abort ? IDLE : SHIFT;
        end

        // Serial outputs are registered from the chain, so each bit appears
        // one clock after the state/counter that selected it.
        SHIFT: begin
          if (bus.abort) begin
            state       <= IDLE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
          end else begin
            ser_out_q   <= chain_msb;
            ser_valid_q <= 1'b1;
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= DONE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end

        // DONE holds until the registered pulse has been presented, so the
        // pulse and the return to IDLE stay aligned with the lagged outputs.
        DONE: begin
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          if (done_q) begin
            done_q <= 1'b0;
            state  <= IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state == LOAD) | (state == SHIFT);

endmodule
